fc_wmem_arbiter: RTL

// - Shares the single-port 64-bit FC weight SRAM between the FC engine (read-only) and the NICE weight loader (read/write).
// - Locks the SRAM to the FC engine for a whole inference, from fc start to result valid.
// - Outside an inference: fixed priority FC > loader, with an anti-starvation slot for the loader.
// - Sits between fc_top's weight address/data pins and the weight SRAM macro.

---
 rtl/fc_wmem_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fc_wmem_arbiter.sv
// fc_wmem_arbiter
//   Shares the single-port FC weight SRAM between the FC engine (read-only)
//   and the NICE weight loader (read/write). From i_fc_start until i_fc_done
//   the FC engine owns the SRAM. Outside an inference, FC has priority over
//   the loader, except that a loader starved for STARVE_LIM cycles is given
//   the next slot.
//
//   Ports
//     i_clk, i_rst_n         clock, asynchronous active-low reset
//     i_fc_start, i_fc_done  inference begin / end pulses
//     i_fc_rd_en/_addr       FC read request
//     o_fc_rd_valid/_data    FC read return (one cycle after grant)
//     i_ld_req/_we/_addr/_wdata  loader request, held until o_ld_gnt
//     o_ld_gnt               loader accepted this cycle (combinational)
//     o_ld_rvalid/_rdata     loader read return (one cycle after grant)
//     o_fc_locked            high while an inference holds the SRAM
//     o_mem_cs/_we/_addr/_wdata, i_mem_rdata  SRAM macro interface
//     o_ld_stall_cnt         loader stall-cycle count
//
//   Build option: define FC_WMEM_STAT_EN to enable the stall counter;
//   otherwise o_ld_stall_cnt is tied to zero.
module fc_wmem_arbiter #(
   parameter int unsigned AW         = 16,
   parameter int unsigned DW         = 64,
   parameter int unsigned STARVE_LIM = 8
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_fc_start,
   input  logic          i_fc_done,
   input  logic          i_fc_rd_en,
   input  logic [AW-1:0] i_fc_rd_addr,
   output logic          o_fc_rd_valid,
   output logic [DW-1:0] o_fc_rd_data,
   input  logic          i_ld_req,
   input  logic          i_ld_we,
   input  logic [AW-1:0] i_ld_addr,
   input  logic [DW-1:0] i_ld_wdata,
   output logic          o_ld_gnt,
   output logic          o_ld_rvalid,
   output logic [DW-1:0] o_ld_rdata,
   output logic          o_fc_locked,
   output logic          o_mem_cs,
   output logic          o_mem_we,
   output logic [AW-1:0] o_mem_addr,
   output logic [DW-1:0] o_mem_wdata,
   input  logic [DW-1:0] i_mem_rdata,
   output logic [15:0]   o_ld_stall_cnt
);

   localparam int unsigned SW = $clog2(STARVE_LIM + 1);
   localparam logic [SW-1:0] LIM = SW'(STARVE_LIM);

   typedef enum logic {IDLE, FC_RUN} state_t;

   state_t        state;
   logic [SW-1:0] starve_cnt;
   logic          fc_gnt;
   logic          ld_gnt;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;

   // Grants are gated by i_rst_n so the SRAM is deselected as soon as
   // reset asserts, not only after the state has fallen back to IDLE.
   always_comb begin
      fc_gnt      = i_rst_n && i_fc_rd_en && ((state == FC_RUN) || (starve_cnt < LIM));
      ld_gnt      = i_rst_n && i_ld_req && (state == IDLE) && !fc_gnt;
      o_ld_gnt    = ld_gnt;
      o_mem_cs    = fc_gnt || ld_gnt;
      o_mem_we    = ld_gnt && i_ld_we;
      o_mem_addr  = addr_q;
      o_mem_wdata = wdata_q;
      if (fc_gnt) begin
         o_mem_addr = i_fc_rd_addr;
      end else if (ld_gnt) begin
         o_mem_addr  = i_ld_addr;
         o_mem_wdata = i_ld_wdata;
      end
   end

   assign o_fc_rd_data = i_mem_rdata;
   assign o_ld_rdata   = i_mem_rdata;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state         <= IDLE;
         o_fc_locked   <= 1'b0;
         starve_cnt    <= '0;
         o_fc_rd_valid <= 1'b0;
         o_ld_rvalid   <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
      end else begin
         case (state)
            IDLE: if (i_fc_start) begin
               state       <= FC_RUN;
               o_fc_locked <= 1'b1;
            end
            FC_RUN: if (i_fc_done) begin
               state       <= IDLE;
               o_fc_locked <= 1'b0;
            end
            default: begin
               state       <= IDLE;
               o_fc_locked <= 1'b0;
            end
         endcase

         if (state == FC_RUN || ld_gnt)
            starve_cnt <= '0;
         else if (i_ld_req && starve_cnt != LIM)
            starve_cnt <= starve_cnt + 1'b1;

         o_fc_rd_valid <= fc_gnt;
         o_ld_rvalid   <= ld_gnt && !i_ld_we;

         if (o_mem_cs) addr_q  <= o_mem_addr;
         if (ld_gnt)   wdata_q <= i_ld_wdata;
      end
   end

`ifdef FC_WMEM_STAT_EN
   logic [15:0] stall_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         stall_cnt <= '0;
      else if (i_fc_start)
         stall_cnt <= '0;
      else if (i_ld_req && !ld_gnt && stall_cnt != '1)
         stall_cnt <= stall_cnt + 16'd1;
   end

   assign o_ld_stall_cnt = stall_cnt;
`else
   assign o_ld_stall_cnt = '0;
`endif

endmodule
